// File: rtl/servo_slew_scheduler.sv
// rtl/servo_slew_scheduler.sv - slew-rate-limited per-channel servo pulse scheduler
//
// Holds a clamped target pulse width per channel. On each i_frame pulse it scans
// every channel in turn, moves the current width toward the target by at most
// STEP, and writes the result to the pulse register bank through a registered
// write port. Commands are accepted only while idle.
//
// Optional feature macro: SERVO_SLEW_SETTLED_EN (adds o_settled).
//
// Ports:
//   i_clock        system clock
//   i_reset        synchronous reset, active-high
//   i_frame        one-cycle pulse per PWM period, starts a scan when idle
//   i_cmd_valid    command strobe
//   i_cmd_channel  command channel index
//   i_cmd_target   requested pulse width (clamped to MIN_PULSE..MAX_PULSE)
//   o_cmd_ready    high while idle; a command is taken when valid and ready
//   o_cmd_err      one-cycle pulse after a command to a nonexistent channel
//   o_wr_valid     pulse bank write strobe
//   o_wr_index     pulse bank write address
//   o_wr_pulse     pulse bank write data
//   o_overrun      one-cycle pulse after an i_frame that arrived mid-scan
//   o_settled      (SERVO_SLEW_SETTLED_EN only) all channels at target after last scan

module servo_slew_scheduler #(
    parameter int CHANNELS  = 12,
    parameter int STEP      = 10,
    parameter int MIN_PULSE = 1000,
    parameter int MAX_PULSE = 2000,
    parameter int CENTER    = 1500
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_frame,
    input  logic        i_cmd_valid,
    input  logic [3:0]  i_cmd_channel,
    input  logic [15:0] i_cmd_target,
    output logic        o_cmd_ready,
    output logic        o_cmd_err,
    output logic        o_wr_valid,
    output logic [3:0]  o_wr_index,
    output logic [15:0] o_wr_pulse,
    output logic        o_overrun
`ifdef SERVO_SLEW_SETTLED_EN
    ,
    output logic        o_settled
`endif
);

    localparam logic [15:0] STEP_W   = 16'(STEP);
    localparam logic [15:0] MIN_W    = 16'(MIN_PULSE);
    localparam logic [15:0] MAX_W    = 16'(MAX_PULSE);
    localparam logic [15:0] CENTER_W = 16'(CENTER);
    localparam logic [4:0]  CHAN_W   = 5'(CHANNELS);
    localparam logic [3:0]  LAST_K   = 4'(CHANNELS - 1);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [15:0] tgt_q [CHANNELS];
    logic [15:0] tgt_d [CHANNELS];
    logic [15:0] cur_q [CHANNELS];
    logic [15:0] cur_d [CHANNELS];
    logic        wr_valid_q, wr_valid_d;
    logic [3:0]  wr_index_q, wr_index_d;
    logic [15:0] wr_pulse_q, wr_pulse_d;
    logic        cmd_err_q, cmd_err_d;
    logic        overrun_q, overrun_d;
    logic [15:0] clamped;
`ifdef SERVO_SLEW_SETTLED_EN
    logic        settled_q, settled_d;
    logic        all_eq;
`endif

    // One slew step: move cur toward tgt by at most STEP. Operands are always
    // within the clamp window, so the subtraction never wraps.
    function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt);
        logic [15:0] d;
        logic [15:0] s;
        d = (cur < tgt) ? (tgt - cur) : (cur - tgt);
        s = (d < STEP_W) ? d : STEP_W;
        if (cur < tgt) begin
            return cur + s;
        end else if (cur > tgt) begin
            return cur - s;
        end
        return cur;
    endfunction

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_cmd_err   = cmd_err_q;
    assign o_wr_valid  = wr_valid_q;
    assign o_wr_index  = wr_index_q;
    assign o_wr_pulse  = wr_pulse_q;
    assign o_overrun   = overrun_q;
`ifdef SERVO_SLEW_SETTLED_EN
    assign o_settled   = settled_q;
`endif

    always_comb begin
        clamped = i_cmd_target;
        if (i_cmd_target < MIN_W) begin
            clamped = MIN_W;
        end else if (i_cmd_target > MAX_W) begin
            clamped = MAX_W;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tgt_d      = tgt_q;
        cur_d      = cur_q;
        wr_valid_d = 1'b0;
        wr_index_d = wr_index_q;
        wr_pulse_d = wr_pulse_q;
        cmd_err_d  = 1'b0;
        overrun_d  = 1'b0;
`ifdef SERVO_SLEW_SETTLED_EN
        settled_d  = settled_q;
        all_eq     = 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                // The command is applied on the same edge that starts a scan,
                // so a simultaneous frame already sees the new target.
                if (i_cmd_valid) begin
                    if ({1'b0, i_cmd_channel} >= CHAN_W) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (i_cmd_channel == 4'(i)) begin
                                tgt_d[i] = clamped;
`ifdef SERVO_SLEW_SETTLED_EN
                                if (clamped != cur_q[i]) begin
                                    settled_d = 1'b0;
                                end
`endif
                            end
                        end
                    end
                end
                if (i_frame) begin
                    state_d = S_SCAN;
                    k_d     = 4'd0;
                end
            end
            S_SCAN: begin
                if (i_frame) begin
                    overrun_d = 1'b1;
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    if (k_q == 4'(i)) begin
                        cur_d[i]   = slew(cur_q[i], tgt_q[i]);
                        wr_pulse_d = cur_d[i];
                    end
                end
                wr_valid_d = 1'b1;
                wr_index_d = k_q;
                if (k_q == LAST_K) begin
                    state_d = S_IDLE;
                    k_d     = 4'd0;
`ifdef SERVO_SLEW_SETTLED_EN
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (cur_d[i] != tgt_q[i]) begin
                            all_eq = 1'b0;
                        end
                    end
                    settled_d = all_eq;
`endif
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            k_q        <= 4'd0;
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= CENTER_W;
                cur_q[i] <= CENTER_W;
            end
            wr_valid_q <= 1'b0;
            wr_index_q <= 4'd0;
            wr_pulse_q <= CENTER_W;
            cmd_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SERVO_SLEW_SETTLED_EN
            settled_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
            wr_valid_q <= wr_valid_d;
            wr_index_q <= wr_index_d;
            wr_pulse_q <= wr_pulse_d;
            cmd_err_q  <= cmd_err_d;
            overrun_q  <= overrun_d;
`ifdef SERVO_SLEW_SETTLED_EN
            settled_q  <= settled_d;
`endif
        end
    end

endmodule

// File: tb/tb_servo_slew_scheduler.sv
// tb/tb_servo_slew_scheduler.sv - self-checking bench for servo_slew_scheduler

module tb_servo_slew_scheduler;

    localparam int CH   = 12;
    localparam int STEP = 10;
    localparam int MINP = 1000;
    localparam int MAXP = 2000;
    localparam int CTR  = 1500;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_frame = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic [3:0]  i_cmd_channel = 4'd0;
    logic [15:0] i_cmd_target = 16'd0;
    logic        o_cmd_ready;
    logic        o_cmd_err;
    logic        o_wr_valid;
    logic [3:0]  o_wr_index;
    logic [15:0] o_wr_pulse;
    logic        o_overrun;
`ifdef SERVO_SLEW_SETTLED_EN
    logic        o_settled;
`endif

    servo_slew_scheduler #(
        .CHANNELS (CH),
        .STEP     (STEP),
        .MIN_PULSE(MINP),
        .MAX_PULSE(MAXP),
        .CENTER   (CTR)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_frame      (i_frame),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd_channel(i_cmd_channel),
        .i_cmd_target (i_cmd_target),
        .o_cmd_ready  (o_cmd_ready),
        .o_cmd_err    (o_cmd_err),
        .o_wr_valid   (o_wr_valid),
        .o_wr_index   (o_wr_index),
        .o_wr_pulse   (o_wr_pulse),
        .o_overrun    (o_overrun)
`ifdef SERVO_SLEW_SETTLED_EN
        ,
        .o_settled    (o_settled)
`endif
    );

    always #5 i_clock = ~i_clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a frame seen while idle advances every channel at once
    // and schedules the expected bank writes by cycle number.
    typedef struct {
        int due;
        int idx;
        int pulse;
    } wr_t;

    wr_t exp_q[$];
    int  m_tgt[CH];
    int  m_cur[CH];
    int  busy  = 0;
    int  cyc   = 0;
    bit  e_err = 1'b0;
    bit  e_ovr = 1'b0;
    bit  chk_en = 1'b0;

    function automatic int clampv(input int v);
        if (v < MINP) return MINP;
        if (v > MAXP) return MAXP;
        return v;
    endfunction

    function automatic int slewv(input int c, input int t);
        int d;
        d = (c > t) ? c - t : t - c;
        if (d > STEP) d = STEP;
        return (c < t) ? c + d : c - d;
    endfunction

    always @(posedge i_clock) begin
        cyc++;
        if (i_reset) begin
            for (int i = 0; i < CH; i++) begin
                m_tgt[i] = CTR;
                m_cur[i] = CTR;
            end
            busy = 0;
            e_err = 1'b0;
            e_ovr = 1'b0;
            exp_q.delete();
        end else begin
            e_err = 1'b0;
            e_ovr = 1'b0;
            if (busy == 0) begin
                if (i_cmd_valid) begin
                    if (int'(i_cmd_channel) >= CH) e_err = 1'b1;
                    else m_tgt[i_cmd_channel] = clampv(int'(i_cmd_target));
                end
                if (i_frame) begin
                    busy = CH;
                    for (int k = 0; k < CH; k++) begin
                        m_cur[k] = slewv(m_cur[k], m_tgt[k]);
                        exp_q.push_back('{cyc + 1 + k, k, m_cur[k]});
                    end
                end
            end else begin
                if (i_frame) e_ovr = 1'b1;
                busy--;
            end
        end
    end

    int last_wr[16];
    int wr_count  = 0;
    int nrdy_cnt  = 0;
    int err_cnt   = 0;
    int ovr_cnt   = 0;

    always @(negedge i_clock) begin
        if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("wr_valid", 32'(o_wr_valid), 32'd1);
                chk("wr_index", 32'(o_wr_index), 32'(exp_q[0].idx));
                chk("wr_pulse", 32'(o_wr_pulse), 32'(exp_q[0].pulse));
                void'(exp_q.pop_front());
            end else begin
                chk("wr_quiet", 32'(o_wr_valid), 32'd0);
            end
            chk("cmd_ready", 32'(o_cmd_ready), 32'(busy == 0));
            chk("cmd_err", 32'(o_cmd_err), 32'(e_err));
            chk("overrun", 32'(o_overrun), 32'(e_ovr));
            if (o_wr_valid) begin
                last_wr[o_wr_index] = int'(o_wr_pulse);
                wr_count++;
            end
            if (!o_cmd_ready) nrdy_cnt++;
            if (o_cmd_err) err_cnt++;
            if (o_overrun) ovr_cnt++;
        end
    end

    task automatic drive(input logic f, input logic v, input logic [3:0] c, input logic [15:0] t);
        i_frame       = f;
        i_cmd_valid   = v;
        i_cmd_channel = c;
        i_cmd_target  = t;
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'd0, 16'd0);
    endtask

    task automatic frame();
        drive(1'b1, 1'b0, 4'd0, 16'd0);
        idle(CH + 2);
    endtask

    task automatic cmd(input logic [3:0] c, input logic [15:0] t);
        drive(1'b0, 1'b1, c, t);
    endtask

    int wc0;
    int nr0;
    int e0;
    int o0;
    int seq3[5];
    bit found;

    initial begin
        seq3[0] = 1510; seq3[1] = 1520; seq3[2] = 1530; seq3[3] = 1540; seq3[4] = 1543;
        for (int i = 0; i < 16; i++) last_wr[i] = -1;

        // Reset state
        i_reset = 1'b1;
        idle(1);
        chk_en = 1'b1;
        idle(1);
        chk("rst_wr_index", 32'(o_wr_index), 32'd0);
        chk("rst_wr_pulse", 32'(o_wr_pulse), 32'(CTR));
        chk("rst_ready", 32'(o_cmd_ready), 32'd1);
        i_reset = 1'b0;
        idle(2);

        // One frame: 12 writes at centre, ready low 12 cycles
        wc0 = wr_count; nr0 = nrdy_cnt;
        frame();
        chk("f1_writes", 32'(wr_count - wc0), 32'd12);
        chk("f1_busy_cycles", 32'(nrdy_cnt - nr0), 32'd12);
        chk("f1_last_idx11", 32'(last_wr[11]), 32'(CTR));

        // Ramp ch3 to 1543
        cmd(4'd3, 16'd1543);
        for (int f = 0; f < 5; f++) begin
            frame();
            chk("ch3_ramp", 32'(last_wr[3]), 32'(seq3[f]));
        end
        frame();
        chk("ch3_hold", 32'(last_wr[3]), 32'd1543);
        chk("ch0_untouched", 32'(last_wr[0]), 32'(CTR));

        // Clamping
        cmd(4'd0, 16'd2500);
        cmd(4'd1, 16'd200);
        frame();
        chk("ch0_first", 32'(last_wr[0]), 32'd1510);
        chk("ch1_first", 32'(last_wr[1]), 32'd1490);
        for (int f = 0; f < 49; f++) frame();
        chk("ch0_clamped", 32'(last_wr[0]), 32'(MAXP));
        chk("ch1_clamped", 32'(last_wr[1]), 32'(MINP));

        // Out-of-range channel
        e0 = err_cnt;
        cmd(4'd14, 16'd1600);
        idle(1);
        chk("err_pulses", 32'(err_cnt - e0), 32'd1);
        wc0 = wr_count;
        frame();
        chk("err_frame_writes", 32'(wr_count - wc0), 32'd12);
        chk("idx14_unwritten", 32'(last_wr[14]), 32'hFFFF_FFFF);

        // Overrun: second frame mid-scan
        wc0 = wr_count; o0 = ovr_cnt;
        drive(1'b1, 1'b0, 4'd0, 16'd0);
        idle(4);
        drive(1'b1, 1'b0, 4'd0, 16'd0);
        idle(CH + 4);
        chk("ovr_writes", 32'(wr_count - wc0), 32'd12);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);

        // Frame and command in the same cycle: scan sees the new target
        drive(1'b1, 1'b1, 4'd5, 16'd1400);
        idle(CH + 2);
        chk("same_cycle_ch5", 32'(last_wr[5]), 32'd1490);

        // Reset mid-scan after ramping ch2
        cmd(4'd2, 16'd1700);
        for (int f = 0; f < 20; f++) frame();
        chk("ch2_ramped", 32'(last_wr[2]), 32'd1700);
        drive(1'b1, 1'b0, 4'd0, 16'd0);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (o_wr_valid && o_wr_index == 4'd6) found = 1'b1;
            else idle(1);
        end
        chk("ch6_write_seen", 32'(found), 32'd1);
        i_reset = 1'b1;
        idle(1);
        i_reset = 1'b0;
        wc0 = wr_count;
        idle(CH + 3);
        chk("no_writes_after_reset", 32'(wr_count - wc0), 32'd0);
        frame();
        chk("ch2_back_center", 32'(last_wr[2]), 32'(CTR));
        chk("ch0_back_center", 32'(last_wr[0]), 32'(CTR));

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)), 16'($urandom_range(0, 3000)));
        end
        idle(CH + 4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
